// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// Provides clog2() and bitrev(); bitrev is also used by twiddle-ROM addressing.
package fft_bitrev_reorder_pkg;

  // Per-issue tag carried alongside the RAM read latency.
  typedef struct packed {
    logic vld;
    logic sop;
    logic eop;
  } rd_tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < v) r = k + 1;
    end
    return r;
  endfunction

  // Reverse the low w bits of v; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    logic [31:0] x;
    r = '0;
    x = v;
    for (int k = 0; k < 32; k++) begin
      if (k < w) r = {r[30:0], x[0]};
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Simple dual-port RAM, one clock, registered read, no reset on data.
// Ports: sys_clk, i_en (global enable), i_we/i_waddr/i_wdata, i_re/i_raddr, o_rdata.
module fft_bitrev_reorder_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          sys_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;
  logic          w_we;
  logic          w_re;

  assign w_we = i_en & i_we;
  assign w_re = i_en & i_re;

  always_ff @(posedge sys_clk) begin
    if (w_we) r_mem[i_waddr] <= i_wdata;
    if (w_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes a bit-reversed frame into one bank while
// the other bank is read out in natural order.
// Ports: sys_clk, sys_rst (sync, high), sys_en (global enable),
//   din_valid/din_sop/din_r/din_i (bit-reversed input stream),
//   dout_valid/dout_sop/dout_eop/dout_r/dout_i (natural-order output),
//   frame_err (sticky, set by a din_sop that lands mid-frame).
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int data_resolution = 16,
  parameter int fft_len         = 64
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       sys_en,
  input  logic                       din_valid,
  input  logic                       din_sop,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic                       dout_valid,
  output logic                       dout_sop,
  output logic                       dout_eop,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i,
  output logic                       frame_err
);

  localparam int AW = clog2(fft_len);
  localparam int DR = data_resolution;
  localparam int DW = 2 * DR;
  localparam logic [AW-1:0] LAST = AW'(fft_len - 1);

  logic          r_wr_bank;
  logic [AW-1:0] r_wr_cnt;
  logic          r_rd_active;
  logic          r_rd_bank;
  logic [AW-1:0] r_rd_cnt;
  rd_tag_t       r_tag;
  logic          r_valid;
  logic          r_sop;
  logic          r_eop;
  logic [DR-1:0] r_dr;
  logic [DR-1:0] r_di;
  logic          r_err;

  logic          w_acc;
  logic          w_mis;
  logic          w_wlast;
  logic          w_rlast;
  logic [AW-1:0] w_widx;
  logic [AW:0]   w_waddr;
  logic [AW:0]   w_raddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;

  assign w_acc   = sys_en & din_valid;
  // A sop mid-frame restarts the same bank at index 0.
  assign w_mis   = w_acc & din_sop & (r_wr_cnt != '0);
  assign w_wlast = w_acc & ~w_mis & (r_wr_cnt == LAST);
  assign w_rlast = r_rd_cnt == LAST;

  assign w_widx  = w_mis ? '0 : AW'(bitrev(32'(r_wr_cnt), AW));
  assign w_waddr = {r_wr_bank, w_widx};
  assign w_raddr = {r_rd_bank, r_rd_cnt};
  assign w_wdata = {din_r, din_i};

  fft_bitrev_reorder_ram #(
    .AW(AW + 1),
    .DW(DW)
  ) u_ram (
    .sys_clk(sys_clk),
    .i_en   (sys_en),
    .i_we   (din_valid),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_re   (r_rd_active),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_active <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_tag       <= '0;
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_dr        <= '0;
      r_di        <= '0;
      r_err       <= 1'b0;
    end else if (sys_en) begin
      if (w_mis) begin
        r_wr_cnt <= AW'(1);
        r_err    <= 1'b1;
      end else if (w_wlast) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else if (w_acc) begin
        r_wr_cnt <= r_wr_cnt + AW'(1);
      end

      // Handover wins over the final issue so frames run back to back.
      if (w_wlast) begin
        r_rd_active <= 1'b1;
        r_rd_bank   <= r_wr_bank;
        r_rd_cnt    <= '0;
      end else if (r_rd_active) begin
        r_rd_cnt <= r_rd_cnt + AW'(1);
        if (w_rlast) r_rd_active <= 1'b0;
      end

      r_tag.vld <= r_rd_active;
      r_tag.sop <= r_rd_active & (r_rd_cnt == '0);
      r_tag.eop <= r_rd_active & w_rlast;

      r_valid <= r_tag.vld;
      r_sop   <= r_tag.sop;
      r_eop   <= r_tag.eop;
      if (r_tag.vld) begin
        r_dr <= w_rdata[DW-1:DR];
        r_di <= w_rdata[DR-1:0];
      end
    end
  end

  assign dout_valid = r_valid;
  assign dout_sop   = r_sop;
  assign dout_eop   = r_eop;
  assign dout_r     = r_dr;
  assign dout_i     = r_di;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with fft_len=8.
// Cycle table for the first frame, then monitor-based frame checks.
module tb_fft_bitrev_reorder;

  localparam int DR = 16;
  localparam int N  = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          sys_en = 1'b1;
  logic          din_valid = 1'b0;
  logic          din_sop = 1'b0;
  logic [DR-1:0] din_r = '0;
  logic [DR-1:0] din_i = '0;
  logic          dout_valid;
  logic          dout_sop;
  logic          dout_eop;
  logic [DR-1:0] dout_r;
  logic [DR-1:0] dout_i;
  logic          frame_err;

  fft_bitrev_reorder #(
    .data_resolution(DR),
    .fft_len        (N)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .sys_en    (sys_en),
    .din_valid (din_valid),
    .din_sop   (din_sop),
    .din_r     (din_r),
    .din_i     (din_i),
    .dout_valid(dout_valid),
    .dout_sop  (dout_sop),
    .dout_eop  (dout_eop),
    .dout_r    (dout_r),
    .dout_i    (dout_i),
    .frame_err (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic signed [31:0] act,
                     logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit v;
    bit s;
    int r;
    bit ev;
    bit es;
    bit ee;
    int er;
  } vec_t;

  typedef struct {
    int r;
    int i;
    bit s;
    bit e;
    int st;
  } rec_t;

  rec_t q[$];
  int   stamp = 0;
  bit   en_e = 1'b0;
  bit   rst_e = 1'b0;
  logic pv;
  logic [DR-1:0] pr;
  int   last_acc = 0;

  always @(posedge sys_clk) begin
    en_e  = sys_en;
    rst_e = sys_rst;
    if (sys_en && !sys_rst) stamp++;
  end

  always @(negedge sys_clk) begin
    if (!rst_e && !en_e) begin
      chk("freeze_valid", 32'(dout_valid), 32'(pv));
      chk("freeze_r", $signed(dout_r), $signed(pr));
    end else if (!rst_e && dout_valid) begin
      q.push_back('{$signed(dout_r), $signed(dout_i),
                    dout_sop, dout_eop, stamp});
    end
    pv = dout_valid;
    pr = dout_r;
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic send_frames(int nfr, int base, int gap,
                             int off_s, int off_n);
    int j;
    int c;
    int v;
    int br[8];
    br = '{0, 4, 2, 6, 1, 5, 3, 7};
    j = 0;
    c = 0;
    while (j < nfr * N) begin
      v = base + 100 * (j / N) + br[j % N];
      din_valid = (gap == 0) || (c % 3 == 0);
      sys_en = !(c >= off_s && c < off_s + off_n);
      din_sop = (j % N == 0);
      din_r = 16'(v);
      din_i = 16'(-v);
      cyc();
      if (din_valid && sys_en) begin
        if (j == N - 1) last_acc = stamp;
        j++;
      end
      c++;
    end
    din_valid = 1'b0;
    din_sop = 1'b0;
    sys_en = 1'b1;
  endtask

  task automatic check_frames(int nfr, int base);
    int idx;
    int e;
    chk("count", q.size(), nfr * N);
    for (int k = 0; k < q.size() && k < nfr * N; k++) begin
      idx = k % N;
      e = base + 100 * (k / N) + idx;
      chk("data_r", q[k].r, e);
      chk("data_i", q[k].i, -e);
      chk("sop", 32'(q[k].s), 32'(idx == 0));
      chk("eop", 32'(q[k].e), 32'(idx == N - 1));
      if (k > 0) chk("contig", q[k].st - q[k-1].st, 1);
    end
    if (q.size() > 0) chk("latency", q[0].st, last_acc + 2);
    q.delete();
  endtask

  vec_t tbl[18];

  initial begin
    tbl = '{
      '{1, 1, 0, 0, 0, 0, 0},
      '{1, 0, 4, 0, 0, 0, 0},
      '{1, 0, 2, 0, 0, 0, 0},
      '{1, 0, 6, 0, 0, 0, 0},
      '{1, 0, 1, 0, 0, 0, 0},
      '{1, 0, 5, 0, 0, 0, 0},
      '{1, 0, 3, 0, 0, 0, 0},
      '{1, 0, 7, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0},
      '{0, 0, 0, 1, 1, 0, 0},
      '{0, 0, 0, 1, 0, 0, 1},
      '{0, 0, 0, 1, 0, 0, 2},
      '{0, 0, 0, 1, 0, 0, 3},
      '{0, 0, 0, 1, 0, 0, 4},
      '{0, 0, 0, 1, 0, 0, 5},
      '{0, 0, 0, 1, 0, 0, 6},
      '{0, 0, 0, 1, 0, 1, 7},
      '{0, 0, 0, 0, 0, 0, 7}
    };

    idle(2);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_sop", 32'(dout_sop), 0);
    chk("rst_eop", 32'(dout_eop), 0);
    chk("rst_r", $signed(dout_r), 0);
    chk("rst_i", $signed(dout_i), 0);
    chk("rst_err", 32'(frame_err), 0);
    sys_rst = 1'b0;
    q.delete();

    for (int k = 0; k < 18; k++) begin
      din_valid = tbl[k].v;
      din_sop = tbl[k].s;
      din_r = 16'(tbl[k].r);
      din_i = 16'(-tbl[k].r);
      cyc();
      if (tbl[k].v) last_acc = stamp;
      chk("t1_valid", 32'(dout_valid), 32'(tbl[k].ev));
      chk("t1_sop", 32'(dout_sop), 32'(tbl[k].es));
      chk("t1_eop", 32'(dout_eop), 32'(tbl[k].ee));
      chk("t1_r", $signed(dout_r), tbl[k].er);
      chk("t1_i", $signed(dout_i), -tbl[k].er);
    end
    din_valid = 1'b0;
    din_sop = 1'b0;
    check_frames(1, 0);

    send_frames(4, 0, 0, -10, 0);
    idle(12);
    check_frames(4, 0);

    send_frames(1, 1000, 1, -10, 0);
    idle(12);
    check_frames(1, 1000);

    chk("err_before", 32'(frame_err), 0);
    for (int k = 0; k < 3; k++) begin
      din_valid = 1'b1;
      din_sop = 1'b0;
      din_r = 16'(900 + k);
      din_i = 16'(-(900 + k));
      cyc();
    end
    send_frames(1, 2000, 0, -10, 0);
    idle(12);
    check_frames(1, 2000);
    chk("err_set", 32'(frame_err), 1);
    idle(5);
    chk("err_sticky", 32'(frame_err), 1);

    send_frames(2, 3000, 0, 11, 3);
    idle(12);
    check_frames(2, 3000);

    chk("err_pre_rst", 32'(frame_err), 1);
    send_frames(1, 5000, 0, -10, 0);
    for (int k = 0; k < 30 && q.size() < 4; k++) begin
      @(negedge sys_clk);
      #1;
    end
    chk("wait_idx3", q.size(), 4);
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk("rst_mid_valid", 32'(dout_valid), 0);
    chk("rst_mid_err", 32'(frame_err), 0);
    idle(14);
    chk("no_out_after_rst", q.size(), 4);
    q.delete();
    send_frames(1, 6000, 0, -10, 0);
    idle(12);
    check_frames(1, 6000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
